// File: rtl/aes_inv_cipher_iter.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher_iter
// Iterative AES inverse cipher (FIPS-197 InvCipher) for AES-128/192/256.
// One decryption round is computed per clock.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : ciphertext and key schedule presented
//   in_ready   : block is idle and accepts a new input (state-only)
//   in_data    : 128-bit ciphertext, byte 0 in [127:120], column-major
//   key_sched  : packed expanded key, round key j at [128*j+127 : 128*j]
//   size       : 00 AES-128, 01 AES-192, 1x AES-256
//   out_valid  : out_data holds a plaintext
//   out_ready  : downstream accepts the plaintext
//   out_data   : 128-bit plaintext, same byte order as in_data
//   busy       : high while a block is being decrypted or held for output
// ---------------------------------------------------------------------------
module aes_inv_cipher_iter (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_data,
    input  logic [1919:0] key_sched,
    input  logic [1:0]    size,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_r;
    logic [127:0]    st_r;
    logic [3:0]      r_r;
    logic [1919:0]   key_r;
    logic [1:0]      size_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            busy_r;

    logic [3:0]      nr_in_s;
    logic [3:0]      nr_cur_s;
    logic [3:0]      rk_idx_s;
    logic [127:0]    rk_s;
    logic [127:0]    sr_s;
    logic [127:0]    sb_s;
    logic [127:0]    ark_s;
    logic [127:0]    mc_s;

    // Number of rounds for a key-size code.
    function automatic logic [3:0] nr_of(input logic [1:0] sz);
        logic [3:0] n;
        case (sz)
            2'b00:   n = 4'd10;
            2'b01:   n = 4'd12;
            default: n = 4'd14;
        endcase
        return n;
    endfunction

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply (shift-and-add).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] a_v;
        p   = 8'h00;
        a_v = a;
        for (int i = 0; i < 8; i++) begin
            p   = p ^ (b[i] ? a_v : 8'h00);
            a_v = xtime(a_v);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2;
        logic [7:0] a3;
        logic [7:0] a12;
        logic [7:0] a15;
        logic [7:0] a240;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
        a15  = gf_mul(a12, a3);
        a240 = gf_mul(a15, a15);
        a240 = gf_mul(a240, a240);
        a240 = gf_mul(a240, a240);
        a240 = gf_mul(a240, a240);
        return gf_mul(gf_mul(a240, a12), a2);
    endfunction

    // Inverse S-box: undo the affine map, then take the field inverse.
    // Bit i of the inverse affine is b[i+2]^b[i+5]^b[i+7]^0x05[i] (indices mod 8),
    // expressed here as right rotations by 2, 5 and 7.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        a = {b[1:0], b[7:2]} ^ {b[4:0], b[7:5]} ^ {b[6:0], b[7]} ^ 8'h05;
        return gf_inv(a);
    endfunction

    // Row k rotates right by k: byte (row r, col c) moves to col (c+r) mod 4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*((c + r) % 4) + r) -: 8] = s[127 - 8*(4*c + r) -: 8];
            end
        end
        return o;
    endfunction

    // Byte-wise inverse substitution.
    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = 128'd0;
        for (int b = 0; b < 16; b++) begin
            o[127 - 8*b -: 8] = inv_sbox(s[127 - 8*b -: 8]);
        end
        return o;
    endfunction

    // InvMixColumns on all four columns with matrix rows {0e,0b,0d,09} rotated.
    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        o = 128'd0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c      -: 8];
            a1 = s[127 - 32*c - 8  -: 8];
            a2 = s[127 - 32*c - 16 -: 8];
            a3 = s[127 - 32*c - 24 -: 8];
            o[127 - 32*c      -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[127 - 32*c - 8  -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[127 - 32*c - 16 -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[127 - 32*c - 24 -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Round datapath: key selection from the latched schedule and one inverse round.
    always_comb begin
        nr_in_s  = nr_of(size);
        nr_cur_s = nr_of(size_r);
        // Never index a key above Nr, even if the counter were corrupted.
        rk_idx_s = (r_r > nr_cur_s) ? nr_cur_s : r_r;
        rk_s     = key_r[{rk_idx_s, 7'd0} +: 128];
        sr_s     = inv_shift_rows(st_r);
        sb_s     = inv_sub_bytes(sr_s);
        ark_s    = sb_s ^ rk_s;
        mc_s     = inv_mix_columns(ark_s);
    end

    // Control FSM with registered handshake outputs and the cipher state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            st_r        <= 128'd0;
            r_r         <= 4'd0;
            key_r       <= 1920'd0;
            size_r      <= 2'b00;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        key_r      <= key_sched;
                        size_r     <= size;
                        st_r       <= in_data ^ key_sched[{nr_in_s, 7'd0} +: 128];
                        r_r        <= nr_in_s - 4'd1;
                        state_r    <= ST_ROUND;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_ROUND: begin
                    if (r_r == 4'd0) begin
                        // Final round carries no InvMixColumns.
                        st_r        <= ark_s;
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        st_r <= mc_s;
                        r_r  <= r_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    r_r         <= 4'd0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_data  = st_r;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_cipher_iter
// Self-checking bench for aes_inv_cipher_iter. Expected plaintexts come from
// FIPS-197 constants or from a forward AES model in this file: a random
// plaintext is encrypted by the model and the DUT must recover it.
// ---------------------------------------------------------------------------
module tb_aes_inv_cipher_iter;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  in_data;
    logic [1919:0] key_sched;
    logic [1:0]    size;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_data;
    logic          busy;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] sbox [256];

    localparam logic [255:0] FIPS_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    typedef struct {
        logic [127:0] ct;
        int           nk;
        logic [1:0]   sz;
        logic [127:0] pt;
        int           lat;
    } vec_t;

    vec_t tbl [4];

    always #5 clk = ~clk;

    aes_inv_cipher_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key_sched (key_sched),
        .size      (size),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box from its definition: field inverse by search, then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox[x] = s;
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [1919:0] rand1920();
        logic [1919:0] v;
        for (int i = 0; i < 60; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Key expansion; slots above Nr are filled with junk the DUT must ignore.
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] ks;
        int            nr;
        nr = nk + 6;
        rc = 8'h01;
        ks = rand1920();
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int j = 0; j <= nr; j++)
            ks[128*j +: 128] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
        return ks;
    endfunction

    // Forward cipher: SubBytes, ShiftRows (row r left by r), MixColumns, AddRoundKey.
    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1919:0] ks, input int nr);
        logic [127:0] s;
        logic [127:0] t;
        logic [127:0] u;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        s = pt ^ ks[127:0];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int b = 0; b < 16; b++) t[127 - 8*b -: 8] = sbox[s[127 - 8*b -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    u[127 - 8*(4*c + r) -: 8] = t[127 - 8*(4*((c + r) % 4) + r) -: 8];
            if (rnd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = u[127 - 32*c      -: 8];
                    a1 = u[127 - 32*c - 8  -: 8];
                    a2 = u[127 - 32*c - 16 -: 8];
                    a3 = u[127 - 32*c - 24 -: 8];
                    u[127 - 32*c      -: 8] = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
                    u[127 - 32*c - 8  -: 8] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
                    u[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
                    u[127 - 32*c - 24 -: 8] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
                end
            end
            s = u ^ ks[128*rnd +: 128];
        end
        return s;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One decrypt with out_ready high; inputs are scrambled right after accept.
    task automatic decrypt_check(input string nm, input logic [127:0] ct, input logic [1919:0] ks,
                                 input logic [1:0] sz, input logic [127:0] exp_pt, input int exp_lat);
        int lat;
        @(negedge clk);
        chk({nm, " in_ready"}, 128'(in_ready), 128'd1);
        in_valid  = 1'b1;
        in_data   = ct;
        key_sched = ks;
        size      = sz;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data   = rand128();
        key_sched = rand1920();
        size      = 2'($urandom());
        chk({nm, " busy"}, 128'(busy), 128'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, " latency"}, 128'(lat), 128'(exp_lat));
        chk({nm, " data"}, out_data, exp_pt);
        @(posedge clk);
        #1;
        chk({nm, " release"}, 128'({out_valid, busy, in_ready}), 128'(3'b001));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [255:0]  key;
        logic [1919:0] ks;
        logic [127:0]  pt;
        logic [1:0]    sz;
        logic [127:0]  pts [3];
        logic [127:0]  cts [3];
        int            acc [3];
        int            nk;
        int            lat;
        int            sent;
        int            got;
        int            seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 128'd0;
        key_sched = 1920'd0;
        size      = 2'b00;
        out_ready = 1'b0;

        build_sbox();

        tbl[0] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 4, 2'b00, FIPS_PT, 10};
        tbl[1] = '{128'hdda97ca4864cdfe06eaf70a0ec0d7191, 6, 2'b01, FIPS_PT, 12};
        tbl[2] = '{128'h8ea2b7ca516745bfeafc49904b496089, 8, 2'b10, FIPS_PT, 14};
        tbl[3] = '{128'h8ea2b7ca516745bfeafc49904b496089, 8, 2'b11, FIPS_PT, 14};

        #12;
        chk("reset flags", 128'({out_valid, busy, in_ready}), 128'(3'b001));
        chk("reset out_data", out_data, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // FIPS-197 vectors
        for (int i = 0; i < 4; i++)
            decrypt_check($sformatf("fips%0d", i), tbl[i].ct, expand(FIPS_KEY, tbl[i].nk),
                          tbl[i].sz, tbl[i].pt, tbl[i].lat);

        // Random round trips through the forward model
        for (int i = 0; i < 8; i++) begin
            sz  = 2'($urandom_range(0, 3));
            nk  = (sz == 2'b00) ? 4 : ((sz == 2'b01) ? 6 : 8);
            key = {rand128(), rand128()};
            ks  = expand(key, nk);
            pt  = rand128();
            decrypt_check($sformatf("rand%0d", i), encrypt(pt, ks, nk + 6), ks, sz, pt, nk + 6);
        end

        // Backpressure: hold output for 20 cycles while inputs churn
        ks = expand(FIPS_KEY, 4);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = tbl[0].ct;
        key_sched = ks;
        size      = 2'b00;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp latency", 128'(lat), 128'd10);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp hold flags", 128'({out_valid, in_ready, busy}), 128'(3'b101));
            chk("bp hold data", out_data, FIPS_PT);
            in_valid  = ~in_valid;
            in_data   = rand128();
            key_sched = rand1920();
            size      = 2'($urandom());
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp to idle", 128'({out_valid, in_ready, busy}), 128'(3'b010));
        @(negedge clk);
        chk("bp no accept", 128'({out_valid, in_ready, busy}), 128'(3'b010));

        // Back-to-back stream of three AES-128 blocks
        for (int i = 0; i < 3; i++) begin
            pts[i] = rand128();
            cts[i] = encrypt(pts[i], ks, 10);
            acc[i] = 0;
        end
        sent = 0;
        got  = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 80 && got < 3; t++) begin
            @(negedge clk);
            if (out_valid) begin
                chk($sformatf("b2b data%0d", got), out_data, pts[got]);
                got++;
            end
            if (sent < 3) begin
                in_valid  = 1'b1;
                in_data   = cts[sent];
                key_sched = ks;
                size      = 2'b00;
                if (in_ready) begin
                    acc[sent] = t;
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("b2b count", 128'(got), 128'd3);
        chk("b2b spacing01", 128'(acc[1] - acc[0]), 128'd12);
        chk("b2b spacing12", 128'(acc[2] - acc[1]), 128'd12);
        @(negedge clk);
        @(negedge clk);

        // Asynchronous reset during round 5 of an AES-256 decrypt
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = tbl[2].ct;
        key_sched = expand(FIPS_KEY, 8);
        size      = 2'b10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst flags", 128'({out_valid, busy, in_ready}), 128'(3'b001));
        chk("rst out_data", out_data, 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst no stale output", 128'(seen), 128'd0);
        decrypt_check("post-reset fips0", tbl[0].ct, expand(FIPS_KEY, 4), 2'b00, FIPS_PT, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_iter.md
# aes_inv_cipher_iter

Iterative AES inverse cipher (FIPS-197 InvCipher) for AES-128/192/256, one round per clock, with valid/ready handshakes on input and output. It is the decrypt-side companion of the combinational encryption core. It consumes the packed expanded key schedule in the same layout that core exports, so one key expansion serves both directions. A single instance decrypts one block at a time and holds its own copy of block, schedule and size for the whole operation.

## Interface
- No parameters; `Nr` = 10/12/14 derives from `size`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: ciphertext block and key schedule are presented.
- `in_ready` out 1: block can accept a new input.
- `in_data` in 128: ciphertext. Bits [127:120] are byte 0 (s[0,0]); byte order is column-major per FIPS-197.
- `key_sched` in 1920: round key j is at bits [128*j+127 : 128*j]. Round key 0 is the cipher key's first 128 bits. Keys above Nr are ignored.
- `size` in 2: 00 = AES-128, 01 = AES-192, 10 or 11 = AES-256.
- `out_valid` out 1: `out_data` holds a plaintext.
- `out_ready` in 1: downstream accepts the plaintext.
- `out_data` out 128: plaintext, same byte order as `in_data`.
- `busy` out 1: high in ROUND or DONE.

## Operation
- FSM states: IDLE, ROUND, DONE.
  - IDLE drives `in_ready`=1.
  - ROUND and DONE drive `in_ready`=0; `in_valid` is ignored there.
- Accept: at a clock edge with `in_valid`&`in_ready`:
  - latch `key_sched` and `size`;
  - `st` <= `in_data` ^ rk[Nr];
  - round counter `r` <= Nr-1;
  - go to ROUND.
- ROUND, when `r` ≥ 1: `st` <= InvMixColumns(InvSubBytes(InvShiftRows(`st`)) ^ rk[r]), then `r` <= `r`-1.
- ROUND, when `r` = 0: `st` <= InvSubBytes(InvShiftRows(`st`)) ^ rk[0], with no InvMixColumns. Go to DONE.
- DONE:
  - `out_valid`=1 and `out_data`=`st`.
  - On `out_ready`=1, go to IDLE. `out_valid` drops on that edge.
  - While `out_ready`=0, `out_data` and `out_valid` hold stable indefinitely.
- Transform definitions:
  - InvShiftRows rotates row k right by k bytes.
  - InvSubBytes uses the FIPS-197 inverse S-box.
  - InvMixColumns uses the matrix {0e,0b,0d,09} over GF(2^8) with polynomial 0x11B.
- All round logic is combinational within one cycle. Keys are read from the latched schedule only, so `key_sched` and `size` may change freely after acceptance.
- Round counter is 4 bits.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0, `st`=0, `r`=0, latched key and size = 0.
- Latency: `out_valid` rises exactly Nr edges after the accepting edge (10, 12 or 14 cycles).
- `busy` rises on the accepting edge. It falls on the output handshake edge.
- Throughput: a new input is accepted no earlier than the edge after the output handshake. Back-to-back period is Nr+2 cycles with `out_ready` tied high.
- `in_ready` is a function of state only, with no combinational path from `in_valid` or `out_ready`.
- Reset asserted mid-ROUND or in DONE:
  - immediately returns to IDLE and clears all outputs;
  - the in-flight block is discarded and no `out_valid` is produced for it.
- `in_valid` held high while busy has no effect. That block is accepted only after the FSM returns to IDLE, if `in_valid` is still high.

## Test plan
- **AES-128 (FIPS-197 C.1):**
  - Stimulus: key 000102…0f expanded, `size`=00, `in_data`=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: `out_valid` exactly 10 cycles later with 00112233445566778899aabbccddeeff.
- **AES-192 (C.2):**
  - Stimulus: key 000102…17, `size`=01, ciphertext dda97ca4864cdfe06eaf70a0ec0d7191.
  - Required: same plaintext after 12 cycles.
- **AES-256 (C.3):**
  - Stimulus: key 000102…1f, ciphertext 8ea2b7ca516745bfeafc49904b496089.
  - Required: same plaintext after 14 cycles for `size`=10, and again for `size`=11.
- **Backpressure:**
  - Stimulus: hold `out_ready`=0 for 20 cycles after `out_valid`. Toggle `in_valid`, `in_data`, `key_sched` and `size` meanwhile.
  - Required: `out_data` stable, `in_ready`=0, no second accept. After `out_ready`=1, IDLE is reached on the next edge.
- **Input latching and back-to-back:**
  - Stimulus: corrupt `key_sched` one cycle after accept.
  - Required: result is still correct.
  - Stimulus: stream 3 AES-128 blocks with `out_ready`=1.
  - Required: accepts spaced 12 cycles apart, all outputs correct.
- **Reset mid-operation:**
  - Stimulus: assert `rst_n`=0 asynchronously at round 5 of an AES-256 decrypt.
  - Required: `out_valid`=0, `busy`=0, `in_ready`=1 immediately; no stale output after release. A fresh C.1 decrypt then passes.
